// File: rtl/instr_fetch_unit_pkg.sv
// Shared RV32I front-end definitions: bubble encoding, fetch FSM states and
// a word-alignment helper.
package RV32I_Inst_Pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if_id.sv
// IF/ID pipeline register. Flush beats hold, hold beats load, and an idle
// unstalled cycle inserts a bubble that keeps the previous address.
import RV32I_Inst_Pkg::*;

module if_id_pipe_reg #(
  parameter logic [31:0] NOP = RV32I_Inst_Pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_stall,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_addr,
  output logic [31:0] o_instr,
  output logic [31:0] o_addr,
  output logic        o_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_instr <= NOP;
      o_addr  <= 32'h0;
      o_valid <= 1'b0;
    end else if (i_flush) begin
      o_instr <= NOP;
      o_valid <= 1'b0;
    end else if (!i_stall) begin
      if (i_load) begin
        o_instr <= i_instr;
        o_addr  <= i_addr;
        o_valid <= 1'b1;
      end else begin
        o_instr <= NOP;
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch: PC, single-outstanding imem request channel,
// one-entry stall buffer, EX redirect and the IF/ID register.
import RV32I_Inst_Pkg::*;

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = RV32I_Inst_Pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_if,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic [31:0] instr_if_id,
  output logic [31:0] instr_addr_if_id,
  output logic        instr_valid_if_id
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_buf, w_buf_nxt;
  logic         w_load;
  logic [31:0]  w_instr;

  assign imem_req_valid = (r_state == S_REQ) && !rst;
  assign imem_req_addr  = r_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_load      = 1'b0;
    w_instr     = imem_rsp_data;
    if (jump_en) begin
      // redirect overrides everything; an in-flight response must be drained
      w_pc_nxt = align_word(jump_addr);
      case (r_state)
        S_REQ:   w_state_nxt = imem_req_ready ? S_DRAIN : S_REQ;
        S_WAIT:  w_state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
        S_HOLD:  w_state_nxt = S_REQ;
        S_DRAIN: w_state_nxt = imem_rsp_valid ? S_REQ : S_DRAIN;
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: if (imem_req_ready) w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (stall_if) begin
              w_buf_nxt   = imem_rsp_data;
              w_state_nxt = S_HOLD;
            end else begin
              w_load      = 1'b1;
              w_pc_nxt    = r_pc + 32'd4;
              w_state_nxt = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall_if) begin
            w_load      = 1'b1;
            w_instr     = r_buf;
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = S_REQ;
          end
        end
        S_DRAIN: if (imem_rsp_valid) w_state_nxt = S_REQ;
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_buf   <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  if_id_pipe_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_flush (jump_en),
    .i_stall (stall_if),
    .i_load  (w_load),
    .i_instr (w_instr),
    .i_addr  (r_pc),
    .o_instr (instr_if_id),
    .o_addr  (instr_addr_if_id),
    .o_valid (instr_valid_if_id)
  );

`ifndef SYNTHESIS
  // a response with nothing outstanding means the memory broke the protocol
  always @(posedge clk) begin
    if (!rst && r_state == S_REQ)
      assert (!imem_rsp_valid) else $error("imem response while no request outstanding");
  end
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the RV32I core: holds the PC and fetches instructions from instruction memory over a valid/ready request channel with a separate response channel.
- Owns the IF/ID pipeline register that feeds the instruction decoder.
- Supports a hazard stall from ID.
- Supports redirect/flush from EX (jump/branch taken).
- At most one memory request outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) written to IF/ID on reset, flush or empty slot.

Ports:
- clk  in  1  core clock, single domain
- rst  in  1  asynchronous reset, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  fetch address, word aligned
- imem_rsp_valid  in  1  response data valid; exactly one per accepted request, ≥1 cycle after acceptance
- imem_rsp_data  in  32  fetched instruction
- stall_if  in  1  hazard unit: hold IF/ID contents
- jump_en  in  1  redirect request from EX
- jump_addr  in  32  redirect target
- instr_if_id  out  32  IF/ID instruction to decoder
- instr_addr_if_id  out  32  IF/ID instruction address
- instr_valid_if_id  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=S_REQ, buffer empty.
  - instr_if_id=NOP_INSTR, instr_addr_if_id=0, instr_valid_if_id=0.
  - imem_req_valid=0 while rst asserted.
- Reset mid-operation aborts any outstanding request. The memory is reset by the same rst, so no stale response can arrive.
- States:
  - S_REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready, go to S_WAIT.
  - S_WAIT: req_valid=0. On rsp_valid with stall_if=0: load IF/ID {rsp_data, pc, valid=1}, pc+=4, go to S_REQ. On rsp_valid with stall_if=1: capture rsp_data in the 1-entry buffer, go to S_HOLD.
  - S_HOLD: req_valid=0. When stall_if=0: load IF/ID from the buffer (addr=pc, valid=1), pc+=4, go to S_REQ.
  - S_DRAIN: req_valid=0. Discard the next rsp_valid, then go to S_REQ.
- IF/ID update rule, each cycle with stall_if=0 and no jump:
  - If a new instruction is produced, load it.
  - Otherwise load a bubble {NOP_INSTR, addr unchanged, valid=0}.
- With stall_if=1 and no jump, IF/ID holds.
- Jump (jump_en=1) has priority over stall and over every other event:
  - IF/ID is flushed to a bubble (valid=0).
  - pc <= {jump_addr[31:2], 2'b00}.
  - S_REQ without handshake this cycle: stay S_REQ. imem_req_addr switches to the target next cycle; the memory tolerates address change on an unaccepted request only in this case.
  - S_REQ with handshake this cycle: go to S_DRAIN.
  - S_WAIT without rsp_valid: go to S_DRAIN.
  - S_WAIT with rsp_valid this cycle: response dropped, go to S_REQ.
  - S_HOLD: buffer dropped, go to S_REQ.
  - S_DRAIN: pc updated, stay S_DRAIN (rsp_valid the same cycle: go to S_REQ).
- Latency and throughput:
  - Request accepted at cycle N, response at N+1: IF/ID valid from N+2. Next request is issued at N+2.
  - Peak throughput is one instruction per 2 cycles.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- imem_rsp_valid in S_REQ is a protocol violation; assert in simulation and otherwise ignore.

Decomposition:
- Add NOP_INSTR and the fetch state enum (S_REQ, S_WAIT, S_HOLD, S_DRAIN, 2-bit) to RV32I_Inst_Pkg.
- Sub-module if_id_pipe_reg: IF/ID register with load/bubble/hold/flush controls and async reset to bubble.

Test Plan:
- Reset release, memory ready=1, 1-cycle latency, rsp=32'h00500093 at 0x0: req_addr=0 in first cycle after reset → IF/ID {0x00500093, 0x0, valid=1} two cycles later; next req_addr=0x4.
- stall_if=1 while response 32'h00208133 for 0x4 arrives: IF/ID unchanged, state S_HOLD, no new request. On stall release → IF/ID {0x00208133, 0x4, 1}, then req_addr=0x8.
- jump_en=1, jump_addr=0x103 in the S_WAIT cycle before the response: the late response is discarded, IF/ID is a bubble (NOP, valid=0), next req_addr=0x100.
- jump_en and stall_if=1 together in S_HOLD: flush wins, IF/ID bubble, buffer dropped, req_addr=jump target.
- imem_req_ready low for 5 cycles: req_valid stays 1 with stable addr, IF/ID fills with bubbles (valid=0) while stall_if=0.
- pc=0xFFFF_FFFC fetch completes → next req_addr=0x0000_0000; assert rst mid-S_WAIT → outputs return to reset values immediately.
